stage_sequencer: RTL and testbench

Generates the per-stage read and write step sequences for one layer pass in the dual-mode DNN datapath. It sits directly upstream of the MEMZ control block and drives that block's `rd_stage`, `wr_stage`, `rd_lstep` and `wr_lstep` inputs. Read-side stages advance every `nstep` cycles. The write side replays the same stage/last-step sequence delayed by a fixed pipeline latency `WR_LAT`. A `hold` input freezes both sides for datapath back-pressure.

---
 rtl/stage_sequencer.sv | 153 +++++++++++++++
 tb/tb_stage_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/stage_sequencer.sv
// stage_sequencer: per-stage read/write step sequencing for one layer pass.
// The read side walks stages 0..last_q, each nstep_q cycles long. The write
// side replays the read beat stream WR_LAT cycles later through a shift
// register. hold freezes every sequencing register for back-pressure.
module stage_sequencer #(
    parameter int unsigned STEP_W = 8,
    parameter int unsigned WR_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [STEP_W-1:0] nstep,
    input  logic [3:0]        last_stage,
    input  logic              hold,
    output logic [3:0]        rd_stage,
    output logic [STEP_W-1:0] rd_step,
    output logic              rd_lstep,
    output logic              rd_valid,
    output logic [3:0]        wr_stage,
    output logic              wr_lstep,
    output logic              wr_valid,
    output logic              busy,
    output logic              done
);

    localparam int unsigned STAGE_W   = 4;
    localparam int unsigned TAIL      = WR_LAT - 1;
    localparam logic [STAGE_W-1:0] MAX_STAGE = STAGE_W'(9);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One beat of the read stream as carried down the write pipeline.
    typedef struct packed {
        logic               valid;
        logic [STAGE_W-1:0] stage;
        logic               lstep;
    } beat_t;

    state_t             state;
    logic [STEP_W-1:0]  nstep_q;
    logic [STAGE_W-1:0] last_q;
    beat_t              pipe [WR_LAT];

    logic [STEP_W-1:0]  nstep_eff;
    logic [STAGE_W-1:0] last_eff;
    beat_t              rd_beat;
    beat_t              wr_tail;
    logic               final_wr;

    // Values captured at start: zero steps means one step, stage index capped at 9.
    assign nstep_eff = (nstep == '0) ? STEP_W'(1) : nstep;
    assign last_eff  = (last_stage > MAX_STAGE) ? MAX_STAGE : last_stage;

    // Last step of the current read stage, derived from registered state only.
    assign rd_lstep = rd_valid && (rd_step == (nstep_q - STEP_W'(1)));

    // Beat entering the write pipeline; idle slots carry all zeros.
    assign rd_beat.valid = rd_valid;
    assign rd_beat.stage = rd_valid ? rd_stage : '0;
    assign rd_beat.lstep = rd_lstep;

    // Write outputs are the pipeline tail.
    assign wr_tail  = pipe[TAIL];
    assign wr_valid = wr_tail.valid;
    assign wr_stage = wr_tail.stage;
    assign wr_lstep = wr_tail.lstep;

    // Final write beat of the pass is sitting at the tail.
    assign final_wr = wr_tail.valid && wr_tail.lstep && (wr_tail.stage == last_q);

    // Sequencing FSM, read counters and write pipeline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            nstep_q  <= STEP_W'(1);
            last_q   <= '0;
            rd_stage <= '0;
            rd_step  <= '0;
            rd_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            for (int i = 0; i < int'(WR_LAT); i++) begin
                pipe[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    for (int i = 0; i < int'(WR_LAT); i++) begin
                        pipe[i] <= '0;
                    end
                    if (start) begin
                        nstep_q  <= nstep_eff;
                        last_q   <= last_eff;
                        rd_stage <= '0;
                        rd_step  <= '0;
                        rd_valid <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                        state    <= RUN;
                    end else if (!hold) begin
                        done <= 1'b0;
                    end
                end

                RUN: begin
                    if (!hold) begin
                        pipe[0] <= rd_beat;
                        for (int i = 1; i < int'(WR_LAT); i++) begin
                            pipe[i] <= pipe[i-1];
                        end
                        if (rd_lstep) begin
                            rd_step <= '0;
                            if (rd_stage == last_q) begin
                                rd_valid <= 1'b0;
                                rd_stage <= '0;
                                state    <= DRAIN;
                            end else begin
                                rd_stage <= rd_stage + STAGE_W'(1);
                            end
                        end else begin
                            rd_step <= rd_step + STEP_W'(1);
                        end
                    end
                end

                DRAIN: begin
                    if (!hold) begin
                        pipe[0] <= rd_beat;
                        for (int i = 1; i < int'(WR_LAT); i++) begin
                            pipe[i] <= pipe[i-1];
                        end
                        if (final_wr) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// tb_stage_sequencer: directed checks of the stage sequencer pass timing.
// Cycle 0 of each test is the cycle in which start is driven high; every
// later cycle is compared as one packed vector of all outputs.
module tb_stage_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] nstep;
    logic [3:0] last_stage;
    logic       hold;
    logic [3:0] rd_stage;
    logic [7:0] rd_step;
    logic       rd_lstep;
    logic       rd_valid;
    logic [3:0] wr_stage;
    logic       wr_lstep;
    logic       wr_valid;
    logic       busy;
    logic       done;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] obs;

    stage_sequencer #(.STEP_W(8), .WR_LAT(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .nstep      (nstep),
        .last_stage (last_stage),
        .hold       (hold),
        .rd_stage   (rd_stage),
        .rd_step    (rd_step),
        .rd_lstep   (rd_lstep),
        .rd_valid   (rd_valid),
        .wr_stage   (wr_stage),
        .wr_lstep   (wr_lstep),
        .wr_valid   (wr_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {10'b0, rd_valid, rd_stage, rd_step, rd_lstep,
                  wr_valid, wr_stage, wr_lstep, busy, done};

    // Compare one observed value against its expectation.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack(input logic rv, input int rs, input int rstp,
                                         input logic rl, input logic wv, input int ws,
                                         input logic wl, input logic bz, input logic dn);
        logic [3:0] rs4;
        logic [7:0] rstp8;
        logic [3:0] ws4;
        rs4   = 4'(rs);
        rstp8 = 8'(rstp);
        ws4   = 4'(ws);
        return {10'b0, rv, rs4, rstp8, rl, wv, ws4, wl, bz, dn};
    endfunction

    // Expected outputs in cycle c of an unheld pass, start in cycle 0, WR_LAT=3.
    function automatic logic [31:0] base_exp(input int c, input int n, input int stages);
        int   r;
        int   w;
        logic rv;
        logic wv;
        r  = n * stages;
        w  = c - 3;
        rv = (c >= 1) && (c <= r);
        wv = (w >= 1) && (w <= r);
        return pack(rv,
                    rv ? (c - 1) / n : 0,
                    rv ? (c - 1) % n : 0,
                    rv && ((c - 1) % n == n - 1),
                    wv,
                    wv ? (w - 1) / n : 0,
                    wv && ((w - 1) % n == n - 1),
                    (c >= 1) && (c <= r + 3),
                    c == r + 4);
    endfunction

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        hold       = 1'b0;
        nstep      = 8'd0;
        last_stage = 4'd0;
        step();
        step();
        check("reset", obs, 32'h0);
        rst = 1'b1;
        step();
        check("idle", obs, 32'h0);

        // Base pass: nstep=4, last_stage=3.
        nstep = 8'd4; last_stage = 4'd3; start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            step();
            start = 1'b0;
            check($sformatf("base c%0d", c), obs, base_exp(c, 4, 4));
        end

        // Hold in cycles 5..6: outputs frozen, later events shifted by 2.
        start = 1'b1;
        for (int c = 1; c <= 26; c++) begin
            int bc;
            step();
            start = 1'b0;
            hold  = (c == 5 || c == 6);
            bc    = (c <= 5) ? c : ((c <= 7) ? 5 : c - 2);
            check($sformatf("hold c%0d", c), obs, base_exp(bc, 4, 4));
        end
        hold = 1'b0;

        // nstep=0 behaves as one step per stage, last_stage=1.
        nstep = 8'd0; last_stage = 4'd1; start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            start = 1'b0;
            check($sformatf("nstep0 c%0d", c), obs, base_exp(c, 1, 2));
        end

        // last_stage=12 clamps to 9: ten stages of one step.
        nstep = 8'd1; last_stage = 4'd12; start = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            start = 1'b0;
            check($sformatf("clamp c%0d", c), obs, base_exp(c, 1, 10));
        end

        // Mid-pass start and config changes are ignored.
        nstep = 8'd4; last_stage = 4'd3; start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            step();
            start = (c == 5);
            if (c == 2) begin
                nstep      = 8'd9;
                last_stage = 4'd7;
            end
            check($sformatf("restart c%0d", c), obs, base_exp(c, 4, 4));
        end

        // Reset sampled at the end of cycle 9 aborts the pass.
        nstep = 8'd4; last_stage = 4'd3; start = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            step();
            start = 1'b0;
            rst   = (c != 9);
            check($sformatf("abort c%0d", c), obs, (c <= 9) ? base_exp(c, 4, 4) : 32'h0);
        end
        rst = 1'b1;

        // Back-to-back: new start in the done cycle.
        nstep = 8'd4; last_stage = 4'd3; start = 1'b1;
        for (int c = 1; c <= 44; c++) begin
            step();
            start = (c == 20);
            check($sformatf("b2b c%0d", c), obs,
                  (c <= 20) ? base_exp(c, 4, 4) : base_exp(c - 20, 4, 4));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
